// File: rtl/core_pkg.sv
// Shared encodings and shadow-entry type for the RV32I pipeline hazard logic.
// Also holds the register-match helper used by the hazard scoreboard.
package core_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   localparam logic [1:0] MEM_OP_NONE  = 2'd0;
   localparam logic [1:0] MEM_OP_LD    = 2'd1;
   localparam logic [1:0] MEM_OP_STORE = 2'd2;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } hz_state_e;

   localparam int NUM_SRC    = 2;
   localparam int NUM_STAGES = 3;
   localparam int SH_EX      = 0;
   localparam int SH_MEM     = 1;
   localparam int SH_WB      = 2;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } shadow_t;

   // x0 is hardwired zero, so a writer to it never produces a hazard.
   function automatic logic entry_match(shadow_t e, logic [4:0] rs, logic used);
      return used && e.valid && e.we && (e.rd != 5'd0) && (e.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB destination shadow plus per-source match and
// forward-select priority (youngest producer wins).
module hazard_scoreboard
   import core_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          advance,
   input  shadow_t                       ex_next,
   input  logic [NUM_SRC-1:0][4:0]       src_reg,
   input  logic [NUM_SRC-1:0]            src_used,
   output logic [NUM_SRC-1:0][1:0]       fwd_sel,
   output logic                          load_hit
);

   shadow_t [NUM_STAGES-1:0]             sh;
   logic    [NUM_SRC-1:0][NUM_STAGES-1:0] hit;
   logic    [NUM_SRC-1:0]                 lhit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= '0;
      end else if (advance) begin
         sh[SH_WB]  <= sh[SH_MEM];
         sh[SH_MEM] <= sh[SH_EX];
         sh[SH_EX]  <= ex_next;
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      for (genvar st = 0; st < NUM_STAGES; st++) begin : g_stage
         assign hit[s][st] = entry_match(sh[st], src_reg[s], src_used[s]);
      end

      // A load still in EX has no data yet; the stall covers it, so select RF.
      assign fwd_sel[s] = hit[s][SH_EX]  ? (sh[SH_EX].is_load ? FWD_RF : FWD_EX) :
                          hit[s][SH_MEM] ? FWD_MEM :
                          hit[s][SH_WB]  ? FWD_WB  : FWD_RF;

      assign lhit[s] = hit[s][SH_EX] & sh[SH_EX].is_load;
   end

   assign load_hit = |lhit;

endmodule

// File: rtl/hazard_controller.sv
// Decode-side sequencing controller: stall/flush/bubble/freeze generation,
// forwarding selects and a saturating load-use stall counter.
module hazard_controller
   import core_pkg::*;
#(
   parameter int         FLUSH_CYCLES = 2,
   parameter logic [1:0] MEM_OP_LOAD  = MEM_OP_LD,
   parameter int         XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1,
   input  logic            id_rs1_used,
   input  logic [4:0]      id_rs2,
   input  logic            id_rs2_used,
   input  logic [4:0]      id_rd,
   input  logic            id_reg_we,
   input  logic [1:0]      id_mem_op,
   input  logic            ex_redirect,
   input  logic            mem_busy,
   output logic            stall_if,
   output logic            stall_id,
   output logic            flush_id,
   output logic            bubble_ex,
   output logic            freeze,
   output logic [1:0]      fwd_rs1_sel,
   output logic [1:0]      fwd_rs2_sel,
   output logic [XLEN-1:0] stall_count
);

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   hz_state_e                  state, state_n;
   logic [2:0]                 cnt, cnt_n;
   logic                       load_hit, load_use, redirect_act, stall_inc;
   shadow_t                    ex_next;
   logic [NUM_SRC-1:0][4:0]    src_reg;
   logic [NUM_SRC-1:0]         src_used;
   logic [NUM_SRC-1:0][1:0]    fwd_sel;

   assign src_reg  = {id_rs2, id_rs1};
   assign src_used = {id_rs2_used, id_rs1_used};

   hazard_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (!mem_busy),
      .ex_next  (ex_next),
      .src_reg  (src_reg),
      .src_used (src_used),
      .fwd_sel  (fwd_sel),
      .load_hit (load_hit)
   );

   assign fwd_rs1_sel = fwd_sel[0];
   assign fwd_rs2_sel = fwd_sel[1];

   assign load_use     = load_hit & id_valid;
   assign redirect_act = (state == ST_FLUSH) | ex_redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Frozen cycles hold the FSM, so a redirect seen under mem_busy is dropped.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (!mem_busy) begin
         case (state)
            ST_RUN: begin
               if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                  state_n = ST_FLUSH;
                  cnt_n   = CNT_INIT;
               end
            end
            ST_FLUSH: begin
               cnt_n = cnt - 3'd1;
               if (cnt == 3'd1) state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
         endcase
      end
   end

   // Priority: memory freeze, then redirect squash, then load-use stall.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
      stall_inc = 1'b0;
      if (mem_busy) begin
         freeze   = 1'b1;
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else if (redirect_act) begin
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (load_use) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
         stall_inc = 1'b1;
      end
   end

   always_comb begin
      ex_next         = '0;
      ex_next.valid   = id_valid & ~bubble_ex;
      ex_next.rd      = id_rd;
      ex_next.we      = id_reg_we;
      ex_next.is_load = (id_mem_op == MEM_OP_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall_inc && (stall_count != '1)) begin
         stall_count <= stall_count + XLEN'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each driven cycle queues its
// hand-derived expected controls, popped and compared at the falling edge.
module tb_hazard_controller;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_valid, id_rs1_used, id_rs2_used, id_reg_we;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic [1:0]      id_mem_op;
   logic            ex_redirect, mem_busy;
   logic            stall_if, stall_id, flush_id, bubble_ex, freeze;
   logic [1:0]      fwd_rs1_sel, fwd_rs2_sel;
   logic [XLEN-1:0] stall_count;

   typedef struct {
      string           tag;
      logic [8:0]      o;
      logic [XLEN-1:0] c;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   hazard_controller #(.FLUSH_CYCLES(2), .MEM_OP_LOAD(2'd1), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs1_used (id_rs1_used),
      .id_rs2      (id_rs2),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_reg_we   (id_reg_we),
      .id_mem_op   (id_mem_op),
      .ex_redirect (ex_redirect),
      .mem_busy    (mem_busy),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .flush_id    (flush_id),
      .bubble_ex   (bubble_ex),
      .freeze      (freeze),
      .fwd_rs1_sel (fwd_rs1_sel),
      .fwd_rs2_sel (fwd_rs2_sel),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got %0h expected %0h", tag, got, want);
   endtask

   // {stall_if, stall_id, flush_id, bubble_ex, freeze, fwd1, fwd2}
   function automatic logic [8:0] ov(input bit si, input bit sd, input bit fl, input bit bb,
                                     input bit fz, input logic [1:0] f1, input logic [1:0] f2);
      return {si, sd, fl, bb, fz, f1, f2};
   endfunction

   task automatic setid(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input logic [4:0] rd, input bit we, input logic [1:0] mop);
      id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_reg_we = we; id_mem_op = mop;
   endtask

   task automatic setctl(input bit redir, input bit busy);
      ex_redirect = redir; mem_busy = busy;
   endtask

   task automatic push(input string tag, input logic [8:0] o, input logic [XLEN-1:0] c);
      exp_t e;
      e.tag = tag; e.o = o; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, ".ctl"}, {55'd0, stall_if, stall_id, flush_id, bubble_ex, freeze,
                               fwd_rs1_sel, fwd_rs2_sel}, {55'd0, e.o});
         chk({e.tag, ".cnt"}, {32'd0, stall_count}, {32'd0, e.c});
      end
   endtask

   // Called at posedge+1 with inputs already set; leaves time at next posedge+1.
   task automatic cyc(input string tag, input logic [8:0] o, input logic [XLEN-1:0] c);
      push(tag, o, c);
      @(negedge clk);
      pop_cmp();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      setid(0, 0, 0, 0, 0, 0, 0, 0);
      setctl(0, 0);
      #2;
      push("reset", 9'd0, 0);
      pop_cmp();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // forwarding priority EX > MEM > WB
      setid(1, 0, 0, 0, 0, 5, 1, 0);     cyc("fw_a", 9'd0, 0);
      setid(1, 0, 0, 0, 0, 5, 1, 0);     cyc("fw_b", 9'd0, 0);
      setid(1, 5, 1, 5, 0, 0, 0, 0);     cyc("fw_ex", ov(0,0,0,0,0,2'd1,2'd0), 0);
      setid(1, 5, 1, 5, 0, 0, 0, 0);     cyc("fw_mem", ov(0,0,0,0,0,2'd2,2'd0), 0);
      setid(1, 5, 1, 5, 1, 0, 0, 0);     cyc("fw_wb", ov(0,0,0,0,0,2'd3,2'd3), 0);

      // load-use
      setid(1, 0, 1, 0, 0, 7, 1, 1);     cyc("lw_x7", 9'd0, 0);
      setid(1, 7, 1, 0, 1, 8, 1, 0);     cyc("lu_stall", ov(1,1,0,1,0,2'd0,2'd0), 0);
      setid(1, 7, 1, 0, 1, 8, 1, 0);     cyc("lu_fwd", ov(0,0,0,0,0,2'd2,2'd0), 1);
      setid(0, 0, 0, 0, 0, 0, 0, 0);     cyc("idle1", 9'd0, 1);

      // load writing x0 never hazards
      setid(1, 0, 0, 0, 0, 0, 1, 1);     cyc("lw_x0", 9'd0, 1);
      setid(1, 0, 1, 0, 1, 0, 0, 0);     cyc("rd_x0", 9'd0, 1);

      // redirect suppresses load-use; redirect during FLUSH ignored
      setid(1, 0, 0, 0, 0, 12, 1, 1);    cyc("lw_x12", 9'd0, 1);
      setid(1, 12, 1, 0, 0, 0, 0, 0);
      setctl(1, 0);                      cyc("redir", ov(0,0,1,1,0,2'd0,2'd0), 1);
      setctl(1, 0);                      cyc("flush2", ov(0,0,1,1,0,2'd2,2'd0), 1);
      setctl(0, 0);
      setid(1, 0, 0, 0, 0, 11, 1, 0);    cyc("post_flush", 9'd0, 1);

      // freeze during pending load-use
      setid(1, 0, 0, 0, 0, 13, 1, 1);    cyc("lw_x13", 9'd0, 1);
      setid(1, 13, 1, 0, 0, 14, 1, 0);
      setctl(0, 1);                      cyc("frz1", ov(1,1,0,0,1,2'd0,2'd0), 1);
      setctl(1, 1);                      cyc("frz2_redir", ov(1,1,0,0,1,2'd0,2'd0), 1);
      setctl(0, 1);                      cyc("frz3", ov(1,1,0,0,1,2'd0,2'd0), 1);
      setctl(0, 0);                      cyc("frz_stall", ov(1,1,0,1,0,2'd0,2'd0), 1);
      cyc("frz_fwd", ov(0,0,0,0,0,2'd2,2'd0), 2);

      // async reset mid-FLUSH
      setid(0, 0, 0, 0, 0, 0, 0, 0);
      setctl(1, 0);                      cyc("redir2", ov(0,0,1,1,0,2'd0,2'd0), 2);
      setctl(0, 0);
      #1;
      push("in_flush", ov(0,0,1,1,0,2'd0,2'd0), 2);
      pop_cmp();
      rst_n = 1'b0;
      #1;
      push("async_rst", 9'd0, 0);
      pop_cmp();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("after_rst", 9'd0, 0);
      setctl(1, 0);                      cyc("redir3", ov(0,0,1,1,0,2'd0,2'd0), 0);
      setctl(0, 0);                      cyc("flush3", ov(0,0,1,1,0,2'd0,2'd0), 0);
      cyc("run3", 9'd0, 0);

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
